// File: rtl/keypad_scan_4x4_if.sv
// Keypad scanner pin/result bundle: matrix drive and sense plus debounced key report.
interface keypad_scan_4x4_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  // slave: the scanner itself; master: the keypad/consumer side
  modport slave  (input row, output col, output key_code, output key_valid, output key_down);
  modport master (output row, input col, input key_code, input key_valid, input key_down);
endinterface

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner: column drive, row synchroniser, whole-scan debounce,
// lowest-index key priority, one-cycle press strobe and held-down level.
module keypad_scan_4x4 #(
  parameter int SCAN_DIV       = 4096,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              CLK,
  input  logic              RST,
  keypad_scan_4x4_if.slave  kp
);
  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] PRESS_DB = 2'd1;
  localparam logic [1:0] DOWN     = 2'd2;

  logic [3:0]    row_s1, row_s2;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [15:0]   snap;
  logic          scan_done;
  logic [1:0]    state;
  logic [3:0]    key_k;
  logic [3:0]    cnt;
  logic [3:0]    cnt_inc;
  logic [3:0]    cand;
  logic          cand_vld;
  logic          sample;
  logic          db_hit;

  assign sample  = (dwell == DW'(SCAN_DIV - 1));
  assign cnt_inc = cnt + 4'd1;
  assign db_hit  = (cnt_inc == 4'(DEBOUNCE_SCANS));

  // Two-flop synchroniser for the asynchronous row inputs (idle rows read high)
  always_ff @(posedge CLK) begin
    if (RST) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= kp.row;
      row_s2 <= row_s1;
    end
  end

  // Column dwell counter, column drive and row snapshot; scanning never pauses
  always_ff @(posedge CLK) begin
    if (RST) begin
      dwell     <= '0;
      col_idx   <= 2'd0;
      kp.col    <= 4'b1110;
      snap      <= 16'h0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= sample && (col_idx == 2'd3);
      if (sample) begin
        dwell                 <= '0;
        col_idx               <= col_idx + 2'd1;
        kp.col                <= ~(4'b0001 << (col_idx + 2'd1));
        snap[4*col_idx +: 4]  <= ~row_s2;
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  // Lowest set snapshot bit is the candidate key
  always_comb begin
    cand_vld = 1'b0;
    cand     = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (snap[i]) begin
        cand_vld = 1'b1;
        cand     = 4'(i);
      end
    end
  end

  // Debounce FSM; only moves on the cycle after a full scan has been captured
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      key_k        <= 4'd0;
      cnt          <= 4'd0;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (cand_vld) begin
              key_k <= cand;
              if (DEBOUNCE_SCANS == 1) begin
                kp.key_code  <= cand;
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
                cnt          <= 4'd0;
                state        <= DOWN;
              end else begin
                cnt   <= 4'd1;
                state <= PRESS_DB;
              end
            end
          end
          PRESS_DB: begin
            if (cand_vld && cand == key_k) begin
              if (db_hit) begin
                kp.key_code  <= key_k;
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
                cnt          <= 4'd0;
                state        <= DOWN;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt   <= 4'd0;
              state <= IDLE;
            end
          end
          DOWN: begin
            // only the accepted key matters for release; others are ignored
            if (!snap[key_k]) begin
              if (db_hit) begin
                kp.key_down <= 1'b0;
                cnt         <= 4'd0;
                state       <= IDLE;
              end else begin
                cnt <= cnt_inc;
              end
            end else begin
              cnt <= 4'd0;
            end
          end
          default: begin
            cnt   <= 4'd0;
            state <= IDLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Directed bench for keypad_scan_4x4 with SCAN_DIV=4, DEBOUNCE_SCANS=4.
// A key matrix model drives rows from the column drive; a monitor logs strobes/edges.
module tb_keypad_scan_4x4;
  localparam int SD   = 4;
  localparam int DB   = 4;
  localparam int SCAN = 4 * SD;
  // align edge A -> scan DB completes at A+DB*SCAN, FSM acts one edge later
  localparam int LAT  = DB * SCAN + 1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  keypad_scan_4x4_if ifc ();

  keypad_scan_4x4 #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DB)) dut (
    .CLK(CLK), .RST(RST), .kp(ifc.slave)
  );

  always #5 CLK = ~CLK;

  logic [15:0] keys = 16'h0;
  int cyc = 0;
  int pulses = 0;
  int pulse_cyc = -1;
  int fall_cyc = -1;
  logic prev_down = 1'b0;
  logic [3:0] prev_col = 4'b1110;
  int n_cmp = 0;
  int n_err = 0;

  // Matrix model: driven column (active-low) exposes its four keys on the rows
  always_comb begin
    ifc.row = 4'hF;
    case (ifc.col)
      4'b1110: ifc.row = ~keys[3:0];
      4'b1101: ifc.row = ~keys[7:4];
      4'b1011: ifc.row = ~keys[11:8];
      4'b0111: ifc.row = ~keys[15:12];
      default: ifc.row = 4'hF;
    endcase
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Log key_valid pulses and key_down falling edges with their cycle numbers
  always @(negedge CLK) begin
    if (ifc.key_valid) begin
      pulses    <= pulses + 1;
      pulse_cyc <= cyc;
    end
    if (prev_down && !ifc.key_down) fall_cyc <= cyc;
    prev_down <= ifc.key_down;
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge CLK);
    #1;
  endtask

  // Wait for the start of a scan (col just wrapped 0111 -> 1110); returns that edge's cycle
  task automatic align(output int a);
    bit ok = 0;
    a = cyc;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge CLK);
      if (prev_col == 4'b0111 && ifc.col == 4'b1110) begin
        ok = 1;
        a  = cyc;
      end
      prev_col = ifc.col;
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL align: no scan wrap seen, col=%b", ifc.col);
    end
  endtask

  task automatic test_reset();
    int d;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_cmp++; if (ifc.col !== 4'b1110) begin n_err++; $display("FAIL rst_col: got %b want 1110", ifc.col); end
    n_cmp++; if (ifc.key_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ifc.key_valid); end
    n_cmp++; if (ifc.key_down !== 1'b0) begin n_err++; $display("FAIL rst_down: got %b want 0", ifc.key_down); end
    n_cmp++; if (ifc.key_code !== 4'd0) begin n_err++; $display("FAIL rst_code: got %0d want 0", ifc.key_code); end
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] exp_col;
      exp_col = ~(4'b0001 << ((k / SD) % 4));
      n_cmp++;
      if (ifc.col !== exp_col) begin
        n_err++; $display("FAIL col_seq[%0d]: got %b want %b", k, ifc.col, exp_col);
      end
      prev_col = ifc.col;
      @(negedge CLK);
    end
    prev_col = ifc.col;
    d = cyc;
  endtask

  task automatic test_single_press();
    int a, p0;
    p0 = pulses;
    align(a);
    keys = 16'h0200;  // key 9: col2 row1
    wait_until(a + LAT + 5);
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL press_pulses: got %0d want 1", pulses - p0); end
    n_cmp++; if (pulse_cyc !== a + LAT) begin n_err++; $display("FAIL press_lat: got %0d want %0d", pulse_cyc - a, LAT); end
    n_cmp++; if (ifc.key_code !== 4'd9) begin n_err++; $display("FAIL press_code: got %0d want 9", ifc.key_code); end
    wait_until(a + LAT + 3 * SCAN);
    n_cmp++; if (ifc.key_down !== 1'b1) begin n_err++; $display("FAIL press_held: got %b want 1", ifc.key_down); end
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL press_once: got %0d want 1", pulses - p0); end
  endtask

  task automatic test_release();
    int a, p0;
    p0 = pulses;
    align(a);
    keys = 16'h0;
    wait_until(a + LAT - 1);
    n_cmp++; if (ifc.key_down !== 1'b1) begin n_err++; $display("FAIL rel_early: got %b want 1", ifc.key_down); end
    wait_until(a + LAT + 5);
    n_cmp++; if (fall_cyc !== a + LAT) begin n_err++; $display("FAIL rel_lat: got %0d want %0d", fall_cyc - a, LAT); end
    n_cmp++; if (ifc.key_down !== 1'b0) begin n_err++; $display("FAIL rel_down: got %b want 0", ifc.key_down); end
    n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL rel_pulse: got %0d want 0", pulses - p0); end
    n_cmp++; if (ifc.key_code !== 4'd9) begin n_err++; $display("FAIL rel_code: got %0d want 9", ifc.key_code); end
  endtask

  task automatic test_bounce();
    int a, p0;
    p0 = pulses;
    for (int s = 0; s < 6; s++) begin
      align(a);
      keys = (s % 2 == 0) ? 16'h0001 : 16'h0000;
    end
    align(a);
    n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL bounce_quiet: got %0d want 0", pulses - p0); end
    keys = 16'h0001;
    wait_until(a + LAT + 5);
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL bounce_pulses: got %0d want 1", pulses - p0); end
    n_cmp++; if (pulse_cyc !== a + LAT) begin n_err++; $display("FAIL bounce_lat: got %0d want %0d", pulse_cyc - a, LAT); end
    n_cmp++; if (ifc.key_code !== 4'd0) begin n_err++; $display("FAIL bounce_code: got %0d want 0", ifc.key_code); end
    align(a);
    keys = 16'h0;
    wait_until(a + LAT + 5);
    n_cmp++; if (ifc.key_down !== 1'b0) begin n_err++; $display("FAIL bounce_rel: got %b want 0", ifc.key_down); end
  endtask

  task automatic test_two_keys();
    int a, p0;
    p0 = pulses;
    align(a);
    keys = 16'h4020;  // keys 5 and 14
    wait_until(a + LAT + 5);
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL two_pulses: got %0d want 1", pulses - p0); end
    n_cmp++; if (ifc.key_code !== 4'd5) begin n_err++; $display("FAIL two_code: got %0d want 5", ifc.key_code); end
    align(a);
    keys = 16'h0020;  // drop key 14 only
    wait_until(a + LAT + 2 * SCAN);
    n_cmp++; if (ifc.key_down !== 1'b1) begin n_err++; $display("FAIL two_rel14: got %b want 1", ifc.key_down); end
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL two_extra: got %0d want 1", pulses - p0); end
    align(a);
    keys = 16'h0;
    wait_until(a + LAT + 5);
    n_cmp++; if (fall_cyc !== a + LAT) begin n_err++; $display("FAIL two_rel5: got %0d want %0d", fall_cyc - a, LAT); end
  endtask

  task automatic test_reset_mid();
    int a, d, p0;
    p0 = pulses;
    align(a);
    keys = 16'h0200;
    wait_until(a + 2 * SCAN + 2);  // two scans counted, still debouncing
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    d = cyc;  // last reset edge: dwell 0, column 0, like a scan start
    n_cmp++; if (ifc.key_code !== 4'd0) begin n_err++; $display("FAIL mid_code: got %0d want 0", ifc.key_code); end
    n_cmp++; if (pulses !== p0) begin n_err++; $display("FAIL mid_nopulse: got %0d want 0", pulses - p0); end
    wait_until(d + LAT + 5);
    n_cmp++; if (pulses - p0 !== 1) begin n_err++; $display("FAIL mid_pulses: got %0d want 1", pulses - p0); end
    n_cmp++; if (pulse_cyc !== d + LAT) begin n_err++; $display("FAIL mid_lat: got %0d want %0d", pulse_cyc - d, LAT); end
    n_cmp++; if (ifc.key_code !== 4'd9) begin n_err++; $display("FAIL mid_code2: got %0d want 9", ifc.key_code); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_release();
    test_bounce();
    test_two_keys();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
